// File: rtl/snap_pkg.sv
// ============================================================================
// Module   : snap_pkg
// Purpose  : Shared constants and helpers for the snapshot UART transmitter:
//            frame header byte, frame lengths, serializer state encoding and
//            the checksum helper used when SNAP_CHECKSUM_EN is defined.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snap_pkg;

    // First byte of every frame; lets the host resynchronise on the stream.
    localparam logic [7:0] SNAP_HDR = 8'hA5;

    // Frame lengths in bytes: header + 8 snapshot bytes, optionally + checksum.
    localparam int unsigned c_frame_len_base = 9;
    localparam int unsigned c_frame_len_chk  = c_frame_len_base + 1;

    // Bit-level serializer state encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_start = 2'd1;
    localparam state_t c_st_data  = 2'd2;
    localparam state_t c_st_stop  = 2'd3;

    // XOR of the eight bytes of a snapshot word.
    function automatic logic [7:0] snap_xor8(input logic [63:0] d);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            x = x ^ d[8*i +: 8];
        end
        return x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// ============================================================================
// Module   : uart_byte_tx
// Purpose  : 8N1 byte serializer. Accepts one byte per valid/ready handshake
//            and shifts it out LSB first framed by a start (0) and stop (1)
//            bit, each bit lasting DIV clock cycles.
// Ports    : clk      - clock, all state on rising edge
//            rst      - asynchronous active-high reset
//            i_valid  - byte available on i_data
//            i_data   - byte to send
//            o_ready  - serializer can take a byte this cycle
//            o_tx     - serial line, idle high
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_tx
    import snap_pkg::*;
#(
    parameter int unsigned DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    // A one-cycle bit period would give a zero-width counter; keep at least 1 bit.
    localparam int unsigned            c_cnt_w    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0]     c_cnt_one  = c_cnt_w'(1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_tx;

    logic                 w_bit_end;
    logic                 w_take;

    assign w_bit_end = (r_cnt == c_cnt_last);

    // Ready in the last cycle of the stop bit as well as in idle, so the next
    // start bit follows the stop bit with no idle gap.
    assign o_ready = (r_state == c_st_idle) ||
                     ((r_state == c_st_stop) && w_bit_end);
    assign w_take  = i_valid && o_ready;
    assign o_tx    = r_tx;

    // The line level is registered alongside the state so the pin never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (w_take) begin
            r_state <= c_st_start;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= i_data;
            r_tx    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_cnt <= '0;
                    r_tx  <= 1'b1;
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_state <= c_st_data;
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= c_st_stop;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/snap_uart_tx.sv
// ============================================================================
// Module   : snap_uart_tx
// Purpose  : On each rising edge of snap_trig (from a slow clock domain),
//            captures a 64-bit debug snapshot and sends it over an 8N1 UART
//            as header 0xA5 followed by the snapshot bytes, MSB byte first.
//            Build option: define SNAP_CHECKSUM_EN to append an XOR checksum
//            byte (10-byte frames instead of 9).
// Ports    : CLK100MHZ  - system clock, all state on rising edge
//            reset      - asynchronous active-high reset
//            snap_trig  - asynchronous trigger level, rising edge = one frame
//            snap_data  - snapshot word, sampled when the trigger is accepted
//            tx_pin_out - UART line, idle high
//            busy       - frame in progress
//            frame_cnt  - completed frames, wraps at 256
//            dropped    - sticky, trigger seen while a frame was in progress
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snap_uart_tx
    import snap_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        snap_trig,
    input  logic [63:0] snap_data,
    output logic        tx_pin_out,
    output logic        busy,
    output logic [7:0]  frame_cnt,
    output logic        dropped
);

    localparam int unsigned c_div = CLK_FREQ / BAUD;
`ifdef SNAP_CHECKSUM_EN
    localparam logic [3:0] c_len = 4'(c_frame_len_chk);
`else
    localparam logic [3:0] c_len = 4'(c_frame_len_base);
`endif

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic [1:0]  r_arm_cnt;
    logic [63:0] r_shadow;
    logic        r_busy;
    logic [3:0]  r_idx;
    logic [7:0]  r_frame_cnt;
    logic        r_dropped;

    logic        w_armed;
    logic        w_edge;
    logic        w_ready;
    logic        w_more;
    logic        w_done;
    logic        w_accept;
    logic        w_valid;
    logic        w_take;
    logic [2:0]  w_byte_sel;
    logic [7:0]  w_byte;

    // The synchronizer comes out of reset holding zeros, so a trigger that is
    // already high at release would look like a rising edge. Edge detection
    // stays masked until the reset zeros have flushed through all three flops.
    assign w_armed = (r_arm_cnt == 2'd3);
    assign w_edge  = r_sync2 && !r_sync3 && w_armed;

    // r_idx is the index of the next byte to hand over; c_len means all handed.
    assign w_more   = r_busy && (r_idx != c_len);
    assign w_done   = r_busy && (r_idx == c_len) && w_ready;
    assign w_accept = w_edge && (!r_busy || w_done);

    // The header is offered in the capture cycle itself, so a frame started
    // on the completion cycle of the previous one runs back-to-back with it.
    assign w_valid = w_more || w_accept;
    assign w_take  = w_valid && w_ready;

    always_comb begin
        w_byte_sel = 3'(4'd8 - r_idx);
        w_byte     = SNAP_HDR;
        if (w_more && (r_idx != 4'd0)) begin
            w_byte = r_shadow[{w_byte_sel, 3'b000} +: 8];
        end
`ifdef SNAP_CHECKSUM_EN
        if (w_more && (r_idx == 4'd9)) begin
            w_byte = snap_xor8(r_shadow);
        end
`endif
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_arm_cnt   <= 2'd0;
            r_shadow    <= '0;
            r_busy      <= 1'b0;
            r_idx       <= '0;
            r_frame_cnt <= '0;
            r_dropped   <= 1'b0;
        end else begin
            r_sync1 <= snap_trig;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end

            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end

            if (w_edge && r_busy && !w_done) begin
                r_dropped <= 1'b1;
            end

            if (w_accept) begin
                // The serializer is always ready here (idle, or in its final
                // stop cycle), so the header is taken in this same cycle.
                r_shadow <= snap_data;
                r_busy   <= 1'b1;
                r_idx    <= 4'd1;
            end else begin
                if (w_done) begin
                    r_busy <= 1'b0;
                end
                if (w_take) begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

    uart_byte_tx #(
        .DIV (c_div)
    ) u_byte_tx (
        .clk     (CLK100MHZ),
        .rst     (reset),
        .i_valid (w_valid),
        .i_data  (w_byte),
        .o_ready (w_ready),
        .o_tx    (tx_pin_out)
    );

    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;
    assign dropped   = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_snap_uart_tx.sv
// ============================================================================
// Module   : tb_snap_uart_tx
// Purpose  : Self-checking bench for snap_uart_tx. The reference model derives
//            the expected line level for every cycle of a frame from the
//            snapshot word alone (header, bytes MSB first, 8N1 bit timing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snap_uart_tx;

    localparam int DIV = 10;
`ifdef SNAP_CHECKSUM_EN
    localparam int FLEN = 10;
`else
    localparam int FLEN = 9;
`endif
    localparam int BCYC = 10 * DIV;
    localparam int FCYC = FLEN * BCYC;

    logic        clk = 1'b0;
    logic        reset;
    logic        snap_trig;
    logic [63:0] snap_data;
    logic        tx_pin_out;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic        dropped;

    logic        trig_f;
    logic [63:0] data_f;
    logic        tx_f;
    logic        busy_f;
    logic [7:0]  cnt_f;
    logic        drop_f;

    int   n_total   = 0;
    int   n_bad     = 0;
    int   busy_low  = 0;
    logic line_q[$];

    always #5 clk = ~clk;

    snap_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) u_dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .snap_trig  (snap_trig),
        .snap_data  (snap_data),
        .tx_pin_out (tx_pin_out),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .dropped    (dropped)
    );

    // One-cycle bit time so that a 256-frame wrap run stays short.
    snap_uart_tx #(.CLK_FREQ(100), .BAUD(100)) u_fast (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .snap_trig  (trig_f),
        .snap_data  (data_f),
        .tx_pin_out (tx_f),
        .busy       (busy_f),
        .frame_cnt  (cnt_f),
        .dropped    (drop_f)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Byte i of the frame carrying snapshot d.
    function automatic logic [7:0] model_byte(input logic [63:0] d, input int i);
        logic [7:0] x;
        x = 8'h00;
        if (i == 0) return 8'hA5;
        if (i <= 8) return d[63 - 8*(i-1) -: 8];
        for (int j = 0; j < 8; j++) x = x ^ d[8*j +: 8];
        return x;
    endfunction

    // Line level k cycles after the first start bit of a frame.
    function automatic logic model_line(input logic [63:0] d, input int k);
        int b;
        int p;
        logic [7:0] by;
        b  = k / BCYC;
        p  = (k % BCYC) / DIV;
        by = model_byte(d, b);
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p-1];
    endfunction

    task automatic step();
        line_q.push_back(tx_pin_out);
        if (busy !== 1'b1) busy_low++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        snap_trig = 1'b0;
        trig_f    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Raise the trigger and wait for busy; returns at the first negedge of the frame.
    task automatic launch(input string tag, input logic [63:0] d);
        int lat;
        snap_data = d;
        snap_trig = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (busy !== 1'b1 && lat < 20);
        check_eq({tag, "_latency"}, lat, 3);
        line_q.delete();
        busy_low = 0;
    endtask

    task automatic verify_frame(input string tag, input logic [63:0] d, input int base);
        int errs;
        logic [7:0]  by;
        logic [63:0] word;
        errs = 0;
        for (int k = 0; k < FCYC; k++) begin
            if (line_q[base + k] !== model_line(d, k)) errs++;
        end
        check_eq({tag, "_wave"}, errs, 0);
        word = '0;
        for (int b = 0; b < FLEN; b++) begin
            for (int j = 0; j < 8; j++) by[j] = line_q[base + b*BCYC + (j+1)*DIV + DIV/2];
            if (b == 0)      check_eq({tag, "_hdr"}, by, 8'hA5);
            else if (b <= 8) word = {word[55:0], by};
            else             check_eq({tag, "_chk"}, by, model_byte(d, 9));
        end
        check_eq({tag, "_data"}, word, d);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d1;
        logic [63:0] d2;
        int          cnt_bad;
        int          n_to;
        int          w;

        reset     = 1'b1;
        snap_trig = 1'b0;
        snap_data = '0;
        trig_f    = 1'b0;
        data_f    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx_pin_out, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_cnt", frame_cnt, 8'd0);
        check_eq("rst_dropped", dropped, 1'b0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // Fixed snapshot.
        d1 = 64'h0123456789ABCDEF;
        launch("s1", d1);
        snap_trig = 1'b0;
        repeat (FCYC) step();
        verify_frame("s1", d1, 0);
        check_eq("s1_busy_hold", busy_low, 0);
        check_eq("s1_busy_end", busy, 1'b0);
        check_eq("s1_idle_line", tx_pin_out, 1'b1);
        check_eq("s1_cnt", frame_cnt, 8'd1);
        check_eq("s1_dropped", dropped, 1'b0);

        // Random snapshots with random idle gaps.
        for (int i = 0; i < 3; i++) begin
            d1 = {$urandom, $urandom};
            repeat ($urandom_range(0, 7)) @(negedge clk);
            launch("s2", d1);
            snap_trig = 1'b0;
            repeat (FCYC) step();
            verify_frame("s2", d1, 0);
            check_eq("s2_cnt", frame_cnt, 8'(2 + i));
        end

        // Second trigger 50 cycles into a frame is dropped.
        do_reset();
        d1 = {$urandom, $urandom};
        launch("s3", d1);
        for (int k = 0; k < FCYC; k++) begin
            if (k == 5) snap_trig = 1'b0;
            if (k == 50) begin
                snap_trig = 1'b1;
                snap_data = ~d1;
            end
            step();
        end
        verify_frame("s3", d1, 0);
        check_eq("s3_dropped", dropped, 1'b1);
        check_eq("s3_cnt", frame_cnt, 8'd1);
        repeat (20) @(negedge clk);
        check_eq("s3_no_restart", busy, 1'b0);
        snap_trig = 1'b0;

        // Snapshot input changes right after capture.
        do_reset();
        d1 = {$urandom, $urandom};
        launch("s4", d1);
        snap_trig = 1'b0;
        snap_data = '1;
        repeat (FCYC) step();
        verify_frame("s4", d1, 0);

        // Trigger edge detected on the completion cycle: back-to-back frames.
        do_reset();
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        launch("s5", d1);
        for (int k = 0; k < 2*FCYC; k++) begin
            if (k == 2) snap_trig = 1'b0;
            if (k == FCYC - 3) begin
                snap_trig = 1'b1;
                snap_data = d2;
            end
            if (k == FCYC + 2) snap_data = ~d2;
            step();
        end
        verify_frame("s5a", d1, 0);
        verify_frame("s5b", d2, FCYC);
        check_eq("s5_busy_hold", busy_low, 0);
        check_eq("s5_busy_end", busy, 1'b0);
        check_eq("s5_cnt", frame_cnt, 8'd2);
        check_eq("s5_dropped", dropped, 1'b0);
        snap_trig = 1'b0;

        // Reset in the middle of a frame, trigger left high across release.
        do_reset();
        d1 = {$urandom, $urandom};
        launch("s6a", d1);
        for (int k = 0; k < FCYC; k++) begin
            if (k == 5)   snap_trig = 1'b0;
            if (k == 50)  snap_trig = 1'b1;
            if (k == 100) snap_trig = 1'b0;
            step();
        end
        check_eq("s6_pre_cnt", frame_cnt, 8'd1);
        check_eq("s6_pre_dropped", dropped, 1'b1);
        repeat (5) @(negedge clk);
        d2 = {$urandom, $urandom};
        launch("s6b", d2);
        repeat (200) step();
        reset = 1'b1;
        #1;
        check_eq("s6_rst_tx", tx_pin_out, 1'b1);
        check_eq("s6_rst_busy", busy, 1'b0);
        check_eq("s6_rst_cnt", frame_cnt, 8'd0);
        check_eq("s6_rst_dropped", dropped, 1'b0);
        @(negedge clk);
        check_eq("s6_rst_tx_next", tx_pin_out, 1'b1);
        reset = 1'b0;
        cnt_bad = 0;
        for (int k = 0; k < 2*FCYC; k++) begin
            @(negedge clk);
            if (tx_pin_out !== 1'b1 || busy !== 1'b0) cnt_bad++;
        end
        check_eq("s6_quiet", cnt_bad, 0);
        snap_trig = 1'b0;
        repeat (6) @(negedge clk);
        d1 = {$urandom, $urandom};
        launch("s6c", d1);
        snap_trig = 1'b0;
        repeat (FCYC) step();
        verify_frame("s6c", d1, 0);
        check_eq("s6c_cnt", frame_cnt, 8'd1);

        // 256 frames on the fast instance: counter wraps to 0.
        do_reset();
        n_to = 0;
        for (int i = 0; i < 256; i++) begin
            data_f = {$urandom, $urandom};
            trig_f = 1'b1;
            w = 0;
            while (busy_f !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (busy_f !== 1'b1) n_to++;
            trig_f = 1'b0;
            w = 0;
            while (busy_f !== 1'b0 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (busy_f !== 1'b0) n_to++;
            if (i == 254) check_eq("fast_cnt_255", cnt_f, 8'd255);
            @(negedge clk);
        end
        check_eq("fast_handshakes", n_to, 0);
        check_eq("fast_cnt_wrap", cnt_f, 8'd0);
        check_eq("fast_dropped", drop_f, 1'b0);
        check_eq("fast_idle_line", tx_f, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
